// File: rtl/tl_a_arb_2to1.sv
// ---------------------------------------------------------------------------
// tl_a_arb_2to1 -- two-master to one-slave TileLink-UL arbiter.
//
// Master 0 (core data port) and master 1 (debug/DMA) share one downstream A
// channel. Round-robin arbitration selects between them, and the grant is held
// for every beat of a multi-beat Put burst. The master index is inserted as the
// top bit of the downstream source. D responses are steered back using that
// bit. Each master may have at most MAX_OUT requests in flight.
//
// Bus widths follow directly from the field packings:
//   A  {opcode[2:0], param[2:0], size[2:0], source[SRC_W-1:0],
//       address[30:0], mask[3:0], data[31:0], corrupt}        = 77+SRC_W bits
//   D  {opcode[2:0], param[1:0], size[2:0], source[SRC_W:0],
//       sink, denied, data[31:0], corrupt}                    = 44+SRC_W bits
//
// Ports
//   clock, reset_n              clock, synchronous active-low reset
//   mN_a_valid/ready/bits       upstream A channel of master N (N = 0, 1)
//   s_a_valid/ready/bits        downstream A channel (source widened by 1 bit)
//   s_d_valid/ready/bits        downstream D channel (source carries the index)
//   mN_d_valid/ready/bits       upstream D channel of master N (index removed)
//   mN_busy                     master N has at least one request in flight
// ---------------------------------------------------------------------------
module tl_a_arb_2to1 #(
   parameter int SRC_W   = 4,
   parameter int MAX_OUT = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                m0_a_valid,
   output logic                m0_a_ready,
   input  logic [76+SRC_W:0]   m0_a_bits,
   input  logic                m1_a_valid,
   output logic                m1_a_ready,
   input  logic [76+SRC_W:0]   m1_a_bits,
   output logic                s_a_valid,
   input  logic                s_a_ready,
   output logic [77+SRC_W:0]   s_a_bits,
   input  logic                s_d_valid,
   output logic                s_d_ready,
   input  logic [43+SRC_W:0]   s_d_bits,
   output logic                m0_d_valid,
   input  logic                m0_d_ready,
   output logic [42+SRC_W:0]   m0_d_bits,
   output logic                m1_d_valid,
   input  logic                m1_d_ready,
   output logic [42+SRC_W:0]   m1_d_bits,
   output logic                m0_busy,
   output logic                m1_busy
);

   localparam int A_W   = 77 + SRC_W;
   localparam int D_W   = 44 + SRC_W;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

   typedef enum logic {IDLE, LOCK} state_t;

   // Beats of an A message: only Put bursts wider than the 32-bit bus span beats.
   function automatic logic [5:0] a_beats(input logic [2:0] op, input logic [2:0] sz);
      if ((op == 3'd0 || op == 3'd1) && sz > 3'd2) a_beats = 6'd1 << (sz - 3'd2);
      else                                           a_beats = 6'd1;
   endfunction

   // Beats of a D message: only AccessAckData wider than the bus spans beats.
   function automatic logic [5:0] d_beats(input logic [2:0] op, input logic [2:0] sz);
      if (op == 3'd1 && sz > 3'd2) d_beats = 6'd1 << (sz - 3'd2);
      else                         d_beats = 6'd1;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
      if (inc && !dec)                 cnt_next = c + CNT_W'(1);
      else if (dec && !inc && c != '0) cnt_next = c - CNT_W'(1);
      else                             cnt_next = c;
   endfunction

   state_t           state, state_nx;
   logic             last_grant;
   logic [5:0]       beat_cnt;
   logic [5:0]       d_cnt;
   logic [CNT_W-1:0] cnt0, cnt1;

   logic             room0, room1, elig0, elig1;
   logic             sel;
   logic [A_W-1:0]   sel_bits;
   logic [5:0]       sel_beats;
   logic             a_fire, first_fire;

   assign room0 = (cnt0 < MAX_C);
   assign room1 = (cnt1 < MAX_C);
   assign elig0 = m0_a_valid && room0;
   assign elig1 = m1_a_valid && room1;

   assign sel_bits  = sel ? m1_a_bits : m0_a_bits;
   assign sel_beats = a_beats(sel_bits[A_W-1 -: 3], sel_bits[A_W-7 -: 3]);
   assign s_a_bits  = {sel_bits[A_W-1:68+SRC_W], sel, sel_bits[67+SRC_W:0]};

   assign a_fire     = s_a_valid && s_a_ready;
   assign first_fire = a_fire && (state == IDLE);

   // State register: last_grant doubles as the burst owner while locked.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         state <= state_nx;
         if (first_fire) begin
            last_grant <= sel;
            beat_cnt   <= sel_beats - 6'd1;
         end else if (state == LOCK && a_fire) begin
            beat_cnt <= beat_cnt - 6'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (first_fire && sel_beats > 6'd1) state_nx = LOCK;
         LOCK:    if (a_fire && beat_cnt == 6'd1)     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // In IDLE a master's ready depends only on its own room and the other
   // master's eligibility, never on its own valid.
   always_comb begin
      sel        = 1'b0;
      s_a_valid  = 1'b0;
      m0_a_ready = 1'b0;
      m1_a_ready = 1'b0;
      if (state == LOCK) begin
         sel        = last_grant;
         s_a_valid  = last_grant ? m1_a_valid : m0_a_valid;
         m0_a_ready = s_a_ready && !last_grant;
         m1_a_ready = s_a_ready &&  last_grant;
      end else begin
         sel        = (elig0 && elig1) ? !last_grant : elig1;
         s_a_valid  = elig0 || elig1;
         m0_a_ready = s_a_ready && room0 && (!elig1 ||  last_grant);
         m1_a_ready = s_a_ready && room1 && (!elig0 || !last_grant);
      end
   end

   // D routing by the source index bit.
   logic       d_idx, d_fire, d_last;
   logic [5:0] d_len;

   assign d_idx      = s_d_bits[35+SRC_W];
   assign m0_d_valid = s_d_valid && !d_idx;
   assign m1_d_valid = s_d_valid &&  d_idx;
   assign s_d_ready  = d_idx ? m1_d_ready : m0_d_ready;
   assign m0_d_bits  = {s_d_bits[D_W-1:36+SRC_W], s_d_bits[34+SRC_W:0]};
   assign m1_d_bits  = {s_d_bits[D_W-1:36+SRC_W], s_d_bits[34+SRC_W:0]};
   assign d_len      = d_beats(s_d_bits[D_W-1 -: 3], s_d_bits[D_W-6 -: 3]);
   assign d_fire     = s_d_valid && s_d_ready;
   assign d_last     = d_fire && (d_cnt == d_len - 6'd1);

   logic inc0, inc1, dec0, dec1;
   assign inc0 = first_fire && !sel;
   assign inc1 = first_fire &&  sel;
   assign dec0 = d_last && !d_idx;
   assign dec1 = d_last &&  d_idx;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         d_cnt <= '0;
         cnt0  <= '0;
         cnt1  <= '0;
      end else begin
         if (d_fire) d_cnt <= d_last ? 6'd0 : d_cnt + 6'd1;
         cnt0 <= cnt_next(cnt0, inc0, dec0);
         cnt1 <= cnt_next(cnt1, inc1, dec1);
      end
   end

   // A response completing with nothing outstanding is a slave protocol error.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (!(dec0 && cnt0 == '0));
         assert (!(dec1 && cnt1 == '0));
      end
   end

   assign m0_busy = (cnt0 != '0);
   assign m1_busy = (cnt1 != '0);

endmodule

// File: tb/tb_tl_a_arb_2to1.sv
// ---------------------------------------------------------------------------
// tb_tl_a_arb_2to1 -- randomized bench with a transaction-level reference.
// Masters issue Get/PutFull/PutPartial requests; the bench plays the slave and
// answers every accepted request in order. The reference tracks requests in
// flight per master, the current burst owner and the round-robin history.
// ---------------------------------------------------------------------------
module tb_tl_a_arb_2to1;
   localparam int SRC_W   = 4;
   localparam int MAX_OUT = 4;
   localparam int A_W     = 77 + SRC_W;
   localparam int D_W     = 44 + SRC_W;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic                m0_a_valid = 1'b0, m1_a_valid = 1'b0;
   logic                m0_a_ready, m1_a_ready;
   logic [A_W-1:0]      m0_a_bits = '0, m1_a_bits = '0;
   logic                s_a_valid;
   logic                s_a_ready = 1'b0;
   logic [A_W:0]        s_a_bits;
   logic                s_d_valid = 1'b0;
   logic                s_d_ready;
   logic [D_W-1:0]      s_d_bits = '0;
   logic                m0_d_valid, m1_d_valid;
   logic                m0_d_ready = 1'b0, m1_d_ready = 1'b0;
   logic [D_W-2:0]      m0_d_bits, m1_d_bits;
   logic                m0_busy, m1_busy;

   always #5 clock = ~clock;

   tl_a_arb_2to1 #(.SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_bits(m0_a_bits),
      .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_bits(m1_a_bits),
      .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits(s_a_bits),
      .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits(s_d_bits),
      .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_bits(m0_d_bits),
      .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_bits(m1_d_bits),
      .m0_busy(m0_busy), .m1_busy(m1_busy)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit              active;
      bit [2:0]        op, param, size;
      bit [SRC_W-1:0]  src;
      int              beats_left;
      bit [30:0]       addr;
      bit [3:0]        mask;
      bit [31:0]       data;
      bit              corrupt;
   } mreq_t;

   typedef struct {
      bit              idx;
      bit [SRC_W-1:0]  src;
      bit [2:0]        op, size;
   } resp_t;

   mreq_t mr[2];
   resp_t dq[$];

   // Reference state: requests in flight, burst owner, beats left, last winner.
   int  outst[2];
   int  burst_left;
   int  owner;
   int  last;
   int  d_beat;
   bit  d_on;
   bit [1:0]  dp;
   bit        dsink, ddenied, dcorr;
   bit [31:0] ddata;

   function automatic int a_len(input bit [2:0] op, input bit [2:0] sz);
      if ((op == 3'd0 || op == 3'd1) && sz > 3'd2) return 1 << (int'(sz) - 2);
      return 1;
   endfunction

   function automatic bit [2:0] resp_op(input resp_t r);
      return (r.op == 3'd4) ? 3'd1 : 3'd0;
   endfunction

   function automatic int d_len(input resp_t r);
      if (resp_op(r) == 3'd1 && r.size > 3'd2) return 1 << (int'(r.size) - 2);
      return 1;
   endfunction

   function automatic logic [A_W-1:0] pack_a(input mreq_t r);
      return {r.op, r.param, r.size, r.src, r.addr, r.mask, r.data, r.corrupt};
   endfunction

   function automatic logic [A_W:0] exp_sa(input mreq_t r, input bit idx);
      return {r.op, r.param, r.size, idx, r.src, r.addr, r.mask, r.data, r.corrupt};
   endfunction

   task automatic rand_payload(input int n);
      mr[n].addr    = 31'($urandom);
      mr[n].mask    = 4'($urandom);
      mr[n].data    = $urandom;
      mr[n].corrupt = 1'($urandom);
   endtask

   task automatic new_req(input int n, input int kind, input int sz);
      mr[n].op         = (kind == 0) ? 3'd4 : (kind == 1) ? 3'd0 : 3'd1;
      mr[n].param      = 3'($urandom);
      mr[n].size       = 3'(sz);
      mr[n].src        = SRC_W'($urandom);
      mr[n].beats_left = a_len(mr[n].op, mr[n].size);
      mr[n].active     = 1'b1;
      rand_payload(n);
   endtask

   task automatic model_reset();
      outst[0] = 0; outst[1] = 0;
      burst_left = 0; owner = 0; last = 1;
      d_beat = 0; d_on = 1'b0;
      dq.delete();
      mr[0].active = 1'b0; mr[1].active = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0; m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_d_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      #1;
      check("rst_m0_busy", m0_busy, 1'b0);
      check("rst_m1_busy", m1_busy, 1'b0);
      check("rst_s_a_valid", s_a_valid, 1'b0);
   endtask

   // One cycle: drive at negedge, compare combinational outputs, advance model.
   task automatic cycle(input int req_pct, input int d_pct);
      int  g;
      bit  ev, a_fire, d_fire;
      bit  mv[2];
      bit  dr[2];
      bit  e[2];
      resp_t h;

      @(negedge clock);
      for (int n = 0; n < 2; n++)
         if (!mr[n].active && $urandom_range(0, 99) < req_pct)
            new_req(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
      m0_a_valid = mr[0].active; m0_a_bits = pack_a(mr[0]);
      m1_a_valid = mr[1].active; m1_a_bits = pack_a(mr[1]);
      s_a_ready  = ($urandom_range(0, 99) < 75);
      if (!d_on && dq.size() > 0 && $urandom_range(0, 99) < d_pct) begin
         d_on = 1'b1; dp = 2'($urandom); dsink = 1'($urandom);
         ddenied = 1'($urandom); dcorr = 1'($urandom); ddata = $urandom;
      end
      if (d_on) begin
         h = dq[0];
         s_d_valid = 1'b1;
         s_d_bits  = {resp_op(h), dp, h.size, h.idx, h.src, dsink, ddenied, ddata, dcorr};
      end else begin
         s_d_valid = 1'b0;
         s_d_bits  = {$urandom, $urandom};
      end
      m0_d_ready = ($urandom_range(0, 99) < 70);
      m1_d_ready = ($urandom_range(0, 99) < 70);
      #1;

      mv[0] = mr[0].active; mv[1] = mr[1].active;
      dr[0] = m0_d_ready;   dr[1] = m1_d_ready;
      if (burst_left > 0) begin
         g = owner; ev = mv[g];
      end else begin
         e[0] = mv[0] && outst[0] < MAX_OUT;
         e[1] = mv[1] && outst[1] < MAX_OUT;
         if (e[0] && e[1]) g = 1 - last;
         else if (e[0])    g = 0;
         else if (e[1])    g = 1;
         else              g = -1;
         ev = (g >= 0);
      end

      check("s_a_valid", s_a_valid, ev);
      if (ev) check("s_a_bits", s_a_bits, exp_sa(mr[g], g[0]));
      if (mv[0]) check("m0_a_ready", m0_a_ready, s_a_ready && ev && g == 0);
      if (mv[1]) check("m1_a_ready", m1_a_ready, s_a_ready && ev && g == 1);
      check("m0_busy", m0_busy, outst[0] != 0);
      check("m1_busy", m1_busy, outst[1] != 0);
      check("m0_d_valid", m0_d_valid, d_on && !h.idx);
      check("m1_d_valid", m1_d_valid, d_on &&  h.idx);
      if (d_on) begin
         check("s_d_ready", s_d_ready, dr[h.idx]);
         check("md_bits", h.idx ? m1_d_bits : m0_d_bits,
               {resp_op(h), dp, h.size, h.src, dsink, ddenied, ddata, dcorr});
      end

      a_fire = ev && s_a_ready;
      d_fire = d_on && dr[h.idx];
      if (a_fire) begin
         if (burst_left == 0) begin
            last = g;
            outst[g]++;
            if (a_len(mr[g].op, mr[g].size) > 1) begin
               burst_left = a_len(mr[g].op, mr[g].size) - 1;
               owner = g;
            end
         end else begin
            burst_left--;
         end
         mr[g].beats_left--;
         if (mr[g].beats_left == 0) begin
            dq.push_back('{idx: g[0], src: mr[g].src, op: mr[g].op, size: mr[g].size});
            mr[g].active = 1'b0;
         end else begin
            rand_payload(g);
         end
      end
      if (d_fire) begin
         d_on = 1'b0;
         d_beat++;
         if (d_beat == d_len(h)) begin
            outst[h.idx]--;
            void'(dq.pop_front());
            d_beat = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clock);
      do_reset();

      // Both masters open with a single-beat Get: master 0 must win the tie.
      new_req(0, 0, 2);
      new_req(1, 0, 2);
      for (int i = 0; i < 8; i++) cycle(0, 0);

      // Slow, medium and fast responders; a rare reset lands mid-burst.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 1500; i++) begin
            if (burst_left > 0 && $urandom_range(0, 149) == 0) do_reset();
            cycle((ph == 0) ? 80 : 50, (ph == 0) ? 8 : (ph == 1) ? 50 : 90);
         end
      end

      // Directed: reset during the second beat of an 8-beat master-0 burst.
      do_reset();
      new_req(0, 1, 5);
      while (mr[0].beats_left > 6 || burst_left == 0) begin
         if (n_checks > 90000) break;
         cycle(0, 0);
      end
      do_reset();
      for (int i = 0; i < 40; i++) cycle(60, 60);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
